// File: rtl/pc_gen_unit_if.sv
// Fetch-side bundle for pc_gen_unit: redirects, stall, fetch handshake, BTB update and
// the generated PC. master = PC generator, slave = pipeline / instruction memory side.
interface pc_gen_unit_if #(
  parameter int ADDR_W    = 32,
  parameter int NUM_REDIR = 2,
  parameter int STALL_W   = 6
);
  localparam int SEL_W = $clog2(NUM_REDIR) + 1;

  logic [STALL_W-1:0]          stall;
  logic [NUM_REDIR-1:0]        redir_valid;
  logic [NUM_REDIR*ADDR_W-1:0] redir_addr;
  logic                        fetch_ready;
  logic                        btb_upd_valid;
  logic [ADDR_W-1:0]           btb_upd_pc;
  logic [ADDR_W-1:0]           btb_upd_target;
  logic [ADDR_W-1:0]           pc;
  logic                        ce;
  logic                        fetch_valid;
  logic                        flush;
  logic [SEL_W-1:0]            redir_sel;
  logic                        btb_hit;

  modport master (
    input  stall, redir_valid, redir_addr, fetch_ready,
           btb_upd_valid, btb_upd_pc, btb_upd_target,
    output pc, ce, fetch_valid, flush, redir_sel, btb_hit
  );

  modport slave (
    output stall, redir_valid, redir_addr, fetch_ready,
           btb_upd_valid, btb_upd_pc, btb_upd_target,
    input  pc, ce, fetch_valid, flush, redir_sel, btb_hit
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Program-counter generator for the IF stage: prioritised redirects, redirect held over a
// stall, optional direct-mapped BTB, sequential PC+STEP, valid/ready fetch handshake.
// Optional feature: define PC_BTB_EN to build the branch-target buffer.
module pc_gen_unit #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                STEP        = 4,
  parameter int                NUM_REDIR   = 2,
  parameter int                STALL_W     = 6,
  parameter int                BTB_ENTRIES = 16
) (
  input  logic          clk,
  input  logic          rst,
  pc_gen_unit_if.master bus
);
  localparam int SEL_W = $clog2(NUM_REDIR) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              flush_q, flush_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  logic              win_valid;
  logic [SEL_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic              ce;
  logic              fire;
  logic              btb_hit;
  logic [ADDR_W-1:0] btb_tgt;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  assign ce   = (state_q == RUN);
  assign fire = ce & bus.fetch_ready;

  // Pick the lowest-index active redirect channel (scan downward so index 0 wins last).
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    for (int unsigned i = NUM_REDIR; i > 0; i--) begin
      if (bus.redir_valid[i-1]) begin
        win_valid = 1'b1;
        win_idx   = SEL_W'(i - 1);
        win_addr  = bus.redir_addr[(i-1)*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef PC_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [ADDR_W-1:0]      btb_tgt_q [BTB_ENTRIES];
  logic [IDX_W-1:0]       rd_idx;
  logic [IDX_W-1:0]       wr_idx;

  assign rd_idx  = pc_q[2 +: IDX_W];
  assign wr_idx  = bus.btb_upd_pc[2 +: IDX_W];
  assign btb_hit = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[ADDR_W-1 -: TAG_W]);
  assign btb_tgt = btb_tgt_q[rd_idx];

  // BTB valid bits: cleared on reset, set by a resolved taken branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid_q <= '0;
    end else if (bus.btb_upd_valid) begin
      btb_valid_q[wr_idx] <= 1'b1;
    end
  end

  // BTB tag/target storage; lookup is combinational, so same-edge update reads old data.
  always_ff @(posedge clk) begin
    if (bus.btb_upd_valid) begin
      btb_tag_q[wr_idx] <= bus.btb_upd_pc[ADDR_W-1 -: TAG_W];
      btb_tgt_q[wr_idx] <= bus.btb_upd_target;
    end
  end
`else
  assign btb_hit = 1'b0;
  assign btb_tgt = '0;
`endif

  // Next-state and next-PC selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    flush_d      = 1'b0;
    sel_d        = sel_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (!bus.stall[0]) begin
          if (win_valid) begin
            // A fresh redirect supersedes any older pending one.
            pc_d         = align(win_addr);
            flush_d      = 1'b1;
            sel_d        = win_idx;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pc_d         = pend_addr_q;
            flush_d      = 1'b1;
            sel_d        = SEL_W'(NUM_REDIR);
            pend_valid_d = 1'b0;
          end else if (fire && btb_hit) begin
            pc_d = align(btb_tgt);
          end else if (fire) begin
            pc_d = pc_q + ADDR_W'(STEP);
          end
        end else if (win_valid) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = align(win_addr);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC, pending redirect and registered flush/select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VEC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      flush_q      <= 1'b0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      flush_q      <= flush_d;
      sel_q        <= sel_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.ce          = ce;
  assign bus.fetch_valid = ce;
  assign bus.flush       = flush_q;
  assign bus.redir_sel   = sel_q;
  assign bus.btb_hit     = btb_hit;
endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed scenarios followed by random traffic, checked
// against a cycle-level reference model of the next-PC rules.
module tb_pc_gen_unit;
  localparam logic [31:0] RV = 32'h100;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_gen_unit_if #(.ADDR_W(32), .NUM_REDIR(NR), .STALL_W(6)) bus ();

  pc_gen_unit #(
    .ADDR_W(32), .RESET_VEC(RV), .STEP(4), .NUM_REDIR(NR), .STALL_W(6), .BTB_ENTRIES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        flush;
    logic [1:0]  sel;
    logic        hit;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  logic [1:0]  m_sel;
  bit          m_bv  [16];
  logic [29:0] m_key [16];
  logic [31:0] m_tgt [16];

  function automatic bit m_hit(input logic [31:0] a);
`ifdef PC_BTB_EN
    int idx;
    idx = int'((a >> 2) % 16);
    return m_bv[idx] && (m_key[idx] == a[31:2]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_pc = RV; m_pend = 0; m_pend_addr = '0; m_sel = '0;
    for (int i = 0; i < 16; i++) m_bv[i] = 0;
  endtask

  // One clock edge of the reference behaviour, from the inputs currently driven.
  task automatic model_step();
    int          win;
    logic [31:0] npc;
    logic [31:0] wa;
    logic [31:0] bt;
    bit          nflush;
    bit          hit_now;
    exp_t        e;
    win = -1;
    for (int i = 0; i < NR; i++)
      if (bus.redir_valid[i] && win < 0) win = i;
    wa      = (win >= 0) ? (bus.redir_addr[win*32 +: 32] & ~32'h3) : '0;
    hit_now = m_hit(m_pc);
    bt      = m_tgt[int'((m_pc >> 2) % 16)];
    npc     = m_pc;
    nflush  = 0;
    if (!m_run) begin
      m_run = 1;
    end else if (!bus.stall[0]) begin
      if (win >= 0) begin
        npc = wa; nflush = 1; m_sel = 2'(win); m_pend = 0;
      end else if (m_pend) begin
        npc = m_pend_addr; nflush = 1; m_sel = 2'(NR); m_pend = 0;
      end else if (bus.fetch_ready && hit_now) begin
        npc = bt & ~32'h3;
      end else if (bus.fetch_ready) begin
        npc = m_pc + 32'd4;
      end
    end else if (win >= 0) begin
      m_pend = 1; m_pend_addr = wa;
    end
`ifdef PC_BTB_EN
    if (bus.btb_upd_valid) begin
      int idx;
      idx = int'((bus.btb_upd_pc >> 2) % 16);
      m_bv[idx]  = 1;
      m_key[idx] = bus.btb_upd_pc[31:2];
      m_tgt[idx] = bus.btb_upd_target;
    end
`endif
    m_pc    = npc;
    e.pc    = m_pc;
    e.ce    = m_run;
    e.flush = nflush;
    e.sel   = m_sel;
    e.hit   = m_hit(m_pc);
    q.push_back(e);
  endtask

  task automatic drive(input bit st, input logic [1:0] rv, input logic [31:0] a0,
                       input logic [31:0] a1, input bit rdy, input bit uv,
                       input logic [31:0] upc, input logic [31:0] utg);
    @(negedge clk);
    bus.stall          = {5'b0, st};
    bus.redir_valid    = rv;
    bus.redir_addr     = {a1, a0};
    bus.fetch_ready    = rdy;
    bus.btb_upd_valid  = uv;
    bus.btb_upd_pc     = upc;
    bus.btb_upd_target = utg;
    model_step();
  endtask

  task automatic idle_inputs();
    bus.stall = '0; bus.redir_valid = '0; bus.redir_addr = '0; bus.fetch_ready = 1'b1;
    bus.btb_upd_valid = 1'b0; bus.btb_upd_pc = '0; bus.btb_upd_target = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_pc", bus.pc, RV);
    chk("rst_ce", bus.ce, 1'b0);
    chk("rst_fv", bus.fetch_valid, 1'b0);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_sel", bus.redir_sel, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    model_step();
  endtask

  // Monitor: compare each post-edge DUT state against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", bus.pc, e.pc);
      chk("ce", bus.ce, e.ce);
      chk("fetch_valid", bus.fetch_valid, e.ce);
      chk("flush", bus.flush, e.flush);
      if (e.flush) chk("redir_sel", bus.redir_sel, e.sel);
      chk("btb_hit", bus.btb_hit, e.hit);
    end
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    do_reset();
    // sequential fetch from reset vector
    repeat (3) drive(0, 2'b00, 0, 0, 1, 0, 0, 0);
    // both channels redirect: channel 0 wins
    drive(0, 2'b11, 32'h200, 32'h300, 1, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1, 0, 0, 0);
    // redirect held over a stall
    drive(1, 2'b10, 0, 32'h400, 1, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 1, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1, 0, 0, 0);
    // back-pressure, redirect inside the window, misaligned target
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b01, 32'h503, 0, 0, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1, 0, 0, 0);
    // wrap at the top of the address space
    drive(0, 2'b01, 32'hFFFF_FFFC, 0, 1, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1, 0, 0, 0);
    // asynchronous reset mid-run
    do_reset();
    // BTB: record 0x10->0x80, then fetch at 0x10
    drive(0, 2'b01, 32'h10, 0, 1, 1, 32'h10, 32'h80);
    drive(0, 2'b00, 0, 0, 1, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1, 0, 0, 0);
    // random traffic in a small address window so BTB entries get reused
    for (int n = 0; n < 500; n++) begin
      bit          st, rdy, uv;
      logic [1:0]  rv;
      logic [31:0] a0, a1, upc, utg;
      st  = ($urandom_range(0, 99) < 20);
      rdy = ($urandom_range(0, 99) < 70);
      rv  = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
      a0  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      a1  = 32'($urandom_range(0, 255));
      uv  = ($urandom_range(0, 99) < 20);
      upc = 32'($urandom_range(0, 255)) & ~32'h3;
      utg = 32'($urandom_range(0, 255));
      drive(st, rv, a0, a1, rdy, uv, upc, utg);
      if (n == 250) do_reset();
    end
    @(negedge clk);
    idle_inputs();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
